// File: rtl/dcache.sv
// ============================================================================
//  Module      : dcache
//  Description : Direct-mapped, write-back, write-allocate data cache.
//                8 lines x 4-byte blocks, 8-bit byte address. Misses stall
//                the CPU through BUSYWAIT while the block is written back
//                (if dirty) and fetched from word-organised data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        READ,
   input  logic        WRITE,
   input  logic [7:0]  ADDRESS,
   input  logic [7:0]  WRITEDATA,
   output logic [7:0]  READDATA,
   output logic        BUSYWAIT,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic [5:0]  MEM_ADDRESS,
   output logic [31:0] MEM_WRITEDATA,
   input  logic [31:0] MEM_READDATA,
   input  logic        MEM_BUSYWAIT
);

   localparam logic [1:0] c_IDLE      = 2'd0;
   localparam logic [1:0] c_WRITEBACK = 2'd1;
   localparam logic [1:0] c_FETCH     = 2'd2;

   // Line storage; only valid/dirty carry a reset value
   logic [7:0]  r_valid;
   logic [7:0]  r_dirty;
   logic [2:0]  r_tag  [0:7];
   logic [31:0] r_data [0:7];

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;

   logic [2:0]  w_tag;
   logic [2:0]  w_index;
   logic [1:0]  w_offset;
   logic [4:0]  w_lane;
   logic        w_req;
   logic        w_hit;
   logic        w_idle;
   logic        w_hit_write;
   logic        w_fill;
   logic [7:0]  w_sel_byte;

   assign w_tag       = ADDRESS[7:5];
   assign w_index     = ADDRESS[4:2];
   assign w_offset    = ADDRESS[1:0];
   assign w_lane      = {w_offset, 3'b000};
   assign w_req       = READ | WRITE;
   assign w_hit       = w_req & r_valid[w_index] & (r_tag[w_index] == w_tag);
   assign w_idle      = (r_state == c_IDLE);
   // READ and WRITE together is treated as a store
   assign w_hit_write = w_idle & w_hit & WRITE;
   assign w_fill      = (r_state == c_FETCH) & ~MEM_BUSYWAIT;
   assign w_sel_byte  = r_data[w_index][w_lane +: 8];

   // Next-state decode for the miss handling sequence
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_req && !w_hit) begin
               if (r_valid[w_index] && r_dirty[w_index]) begin
                  w_state_nxt = c_WRITEBACK;
               end else begin
                  w_state_nxt = c_FETCH;
               end
            end
         end
         c_WRITEBACK: begin
            if (!MEM_BUSYWAIT) begin
               w_state_nxt = c_FETCH;
            end
         end
         c_FETCH: begin
            if (!MEM_BUSYWAIT) begin
               w_state_nxt = c_IDLE;
            end
         end
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // State register; reset aborts any memory transaction in flight
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Valid/dirty bookkeeping: fill cleans the line, hit store dirties it
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_valid <= 8'h00;
         r_dirty <= 8'h00;
      end else if (w_fill) begin
         r_valid[w_index] <= 1'b1;
         r_dirty[w_index] <= 1'b0;
      end else if (w_hit_write) begin
         r_dirty[w_index] <= 1'b1;
      end
   end

   // Data and tag arrays; a store coinciding with reset is discarded
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         if (w_fill) begin
            r_data[w_index] <= MEM_READDATA;
            r_tag[w_index]  <= w_tag;
         end else if (w_hit_write) begin
            r_data[w_index][w_lane +: 8] <= WRITEDATA;
         end
      end
   end

   // Memory-side outputs decoded from the current state
   always_comb begin
      MEM_READ      = (r_state == c_FETCH);
      MEM_WRITE     = (r_state == c_WRITEBACK);
      MEM_ADDRESS   = 6'h00;
      MEM_WRITEDATA = 32'h0000_0000;
      if (r_state == c_WRITEBACK) begin
         MEM_ADDRESS   = {r_tag[w_index], w_index};
         MEM_WRITEDATA = r_data[w_index];
      end else if (r_state == c_FETCH) begin
         MEM_ADDRESS   = {w_tag, w_index};
      end
   end

   // CPU-side outputs: stall on any pending non-hit, return byte on hit load
   always_comb begin
      BUSYWAIT = w_req & ~(w_idle & w_hit);
      READDATA = 8'h00;
      if (w_idle && w_hit && READ && !WRITE) begin
         READDATA = w_sel_byte;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dcache.sv
// ============================================================================
//  Module      : tb_dcache
//  Description : Self-checking bench for dcache with a latency-programmable
//                memory and a behavioural cache/memory reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        READ = 1'b0;
   logic        WRITE = 1'b0;
   logic [7:0]  ADDRESS = 8'h00;
   logic [7:0]  WRITEDATA = 8'h00;
   logic [7:0]  READDATA;
   logic        BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA;
   logic        MEM_BUSYWAIT;

   dcache u_dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .READ          (READ),
      .WRITE         (WRITE),
      .ADDRESS       (ADDRESS),
      .WRITEDATA     (WRITEDATA),
      .READDATA      (READDATA),
      .BUSYWAIT      (BUSYWAIT),
      .MEM_READ      (MEM_READ),
      .MEM_WRITE     (MEM_WRITE),
      .MEM_ADDRESS   (MEM_ADDRESS),
      .MEM_WRITEDATA (MEM_WRITEDATA),
      .MEM_READDATA  (MEM_READDATA),
      .MEM_BUSYWAIT  (MEM_BUSYWAIT)
   );

   always #5 CLK = ~CLK;

   // ---------------- memory environment ----------------
   logic [31:0] mem [0:63];
   int          lat = 0;
   int          r_cnt = 0;

   assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (r_cnt < lat);
   assign MEM_READDATA = mem[MEM_ADDRESS];

   // Memory busy counter and write commit
   always @(posedge CLK) begin
      if (!(MEM_READ | MEM_WRITE)) begin
         r_cnt <= 0;
      end else if (MEM_BUSYWAIT) begin
         r_cnt <= r_cnt + 1;
      end else begin
         r_cnt <= 0;
         if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
      end
   end

   // Transaction monitor sampled mid low phase
   int          n_rd_done, n_wr_done, rd_cycles, wr_cycles, both_high;
   logic [5:0]  last_rd_addr, last_wr_addr;
   logic [31:0] last_wr_data;

   initial both_high = 0;

   always @(negedge CLK) begin
      #2;
      if (MEM_READ && MEM_WRITE) both_high++;
      if (MEM_READ) begin
         rd_cycles++;
         if (!MEM_BUSYWAIT) begin
            n_rd_done++;
            last_rd_addr = MEM_ADDRESS;
         end
      end
      if (MEM_WRITE) begin
         wr_cycles++;
         if (!MEM_BUSYWAIT) begin
            n_wr_done++;
            last_wr_addr = MEM_ADDRESS;
            last_wr_data = MEM_WRITEDATA;
         end
      end
   end

   // ---------------- reference model ----------------
   bit          m_valid [0:7];
   bit          m_dirty [0:7];
   logic [2:0]  m_tag   [0:7];
   logic [31:0] m_data  [0:7];
   logic [31:0] m_mem   [0:63];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
      end
   endtask

   // Run one CPU access and compare against the model
   task automatic do_access(input bit wr, input logic [7:0] addr,
                            input logic [7:0] wd, input string tag);
      logic [2:0]  t, idx;
      logic [1:0]  off;
      bit          hit, wb, timeout;
      logic [5:0]  wb_addr, f_addr;
      logic [31:0] wb_data;
      logic [7:0]  exp_rd, got_rd;
      int          exp_stall, stalls;

      t = addr[7:5]; idx = addr[4:2]; off = addr[1:0];
      hit = m_valid[idx] && (m_tag[idx] == t);
      wb = 0; wb_addr = '0; wb_data = '0; f_addr = '0;
      exp_stall = 0;
      if (!hit) begin
         wb = m_valid[idx] && m_dirty[idx];
         exp_stall = 1 + (lat + 1);
         if (wb) begin
            wb_addr = {m_tag[idx], idx};
            wb_data = m_data[idx];
            m_mem[wb_addr] = wb_data;
            exp_stall += lat + 1;
         end
         f_addr = {t, idx};
         m_data[idx]  = m_mem[f_addr];
         m_tag[idx]   = t;
         m_valid[idx] = 1;
         m_dirty[idx] = 0;
      end
      if (wr) begin
         m_data[idx][off*8 +: 8] = wd;
         m_dirty[idx] = 1;
         exp_rd = 8'h00;
      end else begin
         exp_rd = m_data[idx][off*8 +: 8];
      end

      @(negedge CLK);
      READ = !wr; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
      n_rd_done = 0; n_wr_done = 0; rd_cycles = 0; wr_cycles = 0;
      stalls = 0; timeout = 0;
      forever begin
         #1;
         if (!BUSYWAIT) break;
         stalls++;
         if (stalls > 300) begin
            timeout = 1;
            break;
         end
         @(negedge CLK);
      end
      got_rd = READDATA;
      @(posedge CLK);
      #1;
      READ = 0; WRITE = 0;

      if (timeout) begin
         check({tag, "_timeout"}, 1, 0);
      end else begin
         check({tag, "_stall"}, stalls, exp_stall);
         check({tag, "_rdata"}, got_rd, exp_rd);
         check({tag, "_nfetch"}, n_rd_done, hit ? 0 : 1);
         check({tag, "_rdcyc"}, rd_cycles, hit ? 0 : lat + 1);
         check({tag, "_nwb"}, n_wr_done, wb ? 1 : 0);
         check({tag, "_wrcyc"}, wr_cycles, wb ? lat + 1 : 0);
         if (!hit) check({tag, "_faddr"}, last_rd_addr, f_addr);
         if (wb) begin
            check({tag, "_wbaddr"}, last_wr_addr, wb_addr);
            check({tag, "_wbdata"}, last_wr_data, wb_data);
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge CLK);
      RESET = 1; READ = 1; ADDRESS = 8'h00;
      @(posedge CLK); @(posedge CLK);
      #1;
      check("rst_busy_req", BUSYWAIT, 1);
      check("rst_rdata", READDATA, 0);
      check("rst_mread", MEM_READ, 0);
      check("rst_mwrite", MEM_WRITE, 0);
      check("rst_maddr", MEM_ADDRESS, 0);
      check("rst_mwdata", MEM_WRITEDATA, 0);
      READ = 0;
      #1;
      check("rst_busy_idle", BUSYWAIT, 0);
      @(negedge CLK);
      RESET = 0;
      model_reset();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'h4433_2211;
      for (int i = 0; i < 64; i++) m_mem[i] = mem[i];

      // Directed sequence, latency 5
      lat = 5;
      apply_reset();
      do_access(0, 8'h00, 8'h00, "rd00");
      do_access(1, 8'h01, 8'hAB, "wr01");
      do_access(0, 8'h01, 8'h00, "rd01");
      do_access(0, 8'h05, 8'h00, "fill05");
      do_access(1, 8'h05, 8'hCD, "wr05");
      do_access(0, 8'h25, 8'h00, "dirty25");
      check("dirty_wb_byte", last_wr_data[15:8], 8'hCD);
      do_access(0, 8'h05, 8'h00, "clean05");
      do_access(0, 8'h25, 8'h00, "clean25");

      // Reset in the third FETCH cycle
      apply_reset();
      begin
         int fc;
         fc = 0;
         @(negedge CLK);
         READ = 1; ADDRESS = 8'h44;
         for (int c = 0; c < 50; c++) begin
            #1;
            if (MEM_READ) fc++;
            if (fc == 3) break;
            @(negedge CLK);
         end
         check("rstmid_reached", fc, 3);
         RESET = 1;
         @(posedge CLK);
         #1;
         check("rstmid_mread", MEM_READ, 0);
         RESET = 0; READ = 0;
         model_reset();
      end
      do_access(0, 8'h44, 8'h00, "rstmid_refetch");

      // Zero-latency memory
      apply_reset();
      lat = 0;
      do_access(0, 8'h10, 8'h00, "zl10");

      // Random traffic with varying latency
      for (int n = 0; n < 150; n++) begin
         logic [7:0] a;
         a = {3'($urandom_range(0, 2)), 5'($urandom)};
         lat = $urandom_range(0, 3);
         do_access(1'($urandom), a, 8'($urandom), "rnd");
      end

      check("never_both", both_high, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache sitting directly downstream of the ALU. The ALU result drives ADDRESS for load/store instructions. Load data returns to the register-file write mux. The block hides the latency of the word-organised data memory behind a BUSYWAIT stall signal to the CPU.

## Interface
- Parameters: none. Geometry is fixed at 8 lines × 4-byte blocks and an 8-bit byte address.
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- READ  in  1  CPU load request; held until BUSYWAIT is low at a rising edge
- WRITE  in  1  CPU store request; same holding rule as READ
- ADDRESS  in  8  byte address (ALU RESULT)
- WRITEDATA  in  8  store byte
- READDATA  out  8  load byte
- BUSYWAIT  out  1  stall request to CPU
- MEM_READ  out  1  block read request to data memory
- MEM_WRITE  out  1  block write request to data memory
- MEM_ADDRESS  out  6  block address {tag, index}
- MEM_WRITEDATA  out  32  block being written back; byte 0 in [7:0]
- MEM_READDATA  in  32  fetched block; byte 0 in [7:0]
- MEM_BUSYWAIT  in  1  memory busy

## Operation
- Address split:
  - tag = ADDRESS[7:5]
  - index = ADDRESS[4:2]
  - offset = ADDRESS[1:0]; selects byte lane offset*8 +: 8
- Per-line state: valid, dirty, tag[2:0], data[31:0]. Only valid and dirty are reset; data and tag are not.
- hit = (READ|WRITE) & valid[index] & (tag[index] == tag).
- READ and WRITE both high is a protocol violation; the cache treats it as WRITE.
- FSM states: IDLE, WRITEBACK, FETCH.
- IDLE, hit:
  - READ: READDATA = selected byte.
  - WRITE: at the rising edge, the byte lane is written and dirty[index] is set.
  - State stays IDLE.
- IDLE, miss:
  - Victim valid and dirty → WRITEBACK.
  - Otherwise → FETCH.
- WRITEBACK:
  - Outputs: MEM_WRITE=1, MEM_ADDRESS={tag[index], index}, MEM_WRITEDATA=data[index].
  - Rising edge with MEM_BUSYWAIT=0 → FETCH.
- FETCH:
  - Outputs: MEM_READ=1, MEM_ADDRESS={ADDRESS[7:5], index}.
  - Rising edge with MEM_BUSYWAIT=0: data[index]←MEM_READDATA, tag←ADDRESS[7:5], valid←1, dirty←0, → IDLE.
  - The request then hits in IDLE.
- Outputs are Moore, decoded from state only:
  - MEM_READ and MEM_WRITE are never high together.
  - MEM_WRITEDATA is 0 outside WRITEBACK.
  - MEM_ADDRESS is 0 in IDLE.
- BUSYWAIT = (READ|WRITE) & !(state==IDLE & hit). It is combinational.
- READDATA = selected byte when state==IDLE & hit & READ; otherwise 8'h00.
- CPU dropping its request mid-miss: the current WRITEBACK/FETCH still completes and the line is filled, with no CPU-side effect.
- Memory contract: MEM_BUSYWAIT rises in the same cycle MEM_READ/MEM_WRITE rises and stays high until data is done. MEM_BUSYWAIT never asserted means a one-cycle transfer.

## Timing
- Reset values, at the edge with RESET=1:
  - state=IDLE, all valid=0, all dirty=0.
  - Hence MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0.
  - BUSYWAIT equals (READ|WRITE), because every access misses.
- RESET overrides all activity, including mid-WRITEBACK/FETCH:
  - The memory request drops in the next cycle.
  - Dirty data is lost.
  - A hit write in the same cycle is discarded.
- Hit latency: 0 stall cycles. Read data is valid in the same cycle; a store commits at that edge.
- Clean miss: 1 (IDLE) + L+1 (FETCH) cycles of BUSYWAIT, then the hit cycle. L = number of cycles MEM_BUSYWAIT is high.
- Dirty miss: adds Lw+1 WRITEBACK cycles before FETCH.
- Write miss: allocate first (fetch block), then the byte is written on the hit edge and the line becomes dirty.
- Same-line repeat accesses after a fill never touch memory until eviction.

## Test plan
- Reset, read 0x00, memory latency 5 (block 0 = 0x44332211):
  - MEM_READ=1 with MEM_ADDRESS=6'h00 for 6 cycles.
  - BUSYWAIT drops one cycle after fill.
  - READDATA=0x11; no MEM_WRITE.
- After the fill above, write 0x01 data 0xAB, then read 0x01:
  - BUSYWAIT stays low for both.
  - READDATA=0xAB; no memory traffic.
- Dirty eviction: write 0x05=0xCD (after fill of block 1), then read 0x25:
  - MEM_WRITE with MEM_ADDRESS=6'h01 and MEM_WRITEDATA[15:8]=0xCD.
  - Then MEM_READ with MEM_ADDRESS=6'h09.
  - READDATA = byte 1 of block 9.
- Clean eviction: read 0x05, then read 0x25:
  - Only MEM_READ 6'h01 then MEM_READ 6'h09.
  - MEM_WRITE never asserted.
- RESET asserted in the 3rd FETCH cycle:
  - MEM_READ=0 on the next cycle.
  - A subsequent read of the same address misses again (full fetch).
- Zero-latency memory (MEM_BUSYWAIT tied 0), read 0x10:
  - BUSYWAIT high for exactly 2 cycles (IDLE, FETCH).
  - Correct byte returned on the third.
